// File: rtl/clk_div_prog.sv
// Runtime-programmable clock/tick divider with a valid/ready period port and boundary-aligned updates.
// Optional duty-cycle programming is enabled by defining CLK_DIV_DUTY_EN.
module clk_div_prog #(
    parameter int WIDTH       = 21,
    parameter int DIV_DEFAULT = 100000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    output logic             clk_out,
    output logic             tick,
    output logic             running
);

    localparam logic [WIDTH-1:0] ONE_C        = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO_C        = WIDTH'(2);
    localparam logic [WIDTH-1:0] DEF_PERIOD_C = WIDTH'(DIV_DEFAULT);
    localparam logic [WIDTH-1:0] DEF_HI_C     = WIDTH'(DIV_DEFAULT / 2);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] period_r;
    logic [WIDTH-1:0] pend_period_r;
    logic             pend_valid_r;
    logic             cfg_ready_r;
    logic             clk_out_r;
    logic             tick_r;
    logic             running_r;

    logic [WIDTH-1:0] last_s;
    logic [WIDTH-1:0] cnt_inc_s;
    logic [WIDTH-1:0] new_period_s;
    logic [WIDTH-1:0] hi_cur_s;
    logic [WIDTH-1:0] lo_s;
    logic             at_end_s;
    logic             boundary_s;
    logic             accept_s;
    logic             apply_s;

`ifdef CLK_DIV_DUTY_EN
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] pend_duty_r;
    logic [WIDTH-1:0] new_hi_s;

    // High time must leave at least one low and one high cycle in the period.
    function automatic logic [WIDTH-1:0] duty_clamp(input logic [WIDTH-1:0] duty,
                                                    input logic [WIDTH-1:0] period);
        logic [WIDTH-1:0] res;
        if (duty == {WIDTH{1'b0}}) begin
            res = ONE_C;
        end else if (duty >= period) begin
            res = period - ONE_C;
        end else begin
            res = duty;
        end
        return res;
    endfunction

    assign hi_cur_s = hi_r;
    assign new_hi_s = duty_clamp(pend_duty_r, new_period_s);
`else
    logic unused_duty_s;

    assign hi_cur_s      = period_r >> 1;
    assign unused_duty_s = ^cfg_duty;
`endif

    // Period-end detection, handshake and boundary decode.
    always_comb begin
        last_s       = period_r - ONE_C;
        at_end_s     = (cnt_r == last_s);
        cnt_inc_s    = cnt_r + ONE_C;
        lo_s         = period_r - hi_cur_s;
        new_period_s = (pend_period_r < TWO_C) ? TWO_C : pend_period_r;
        accept_s     = cfg_valid & cfg_ready_r;
        if (state_r == ST_IDLE) begin
            boundary_s = en;
        end else begin
            boundary_s = at_end_s & en;
        end
        apply_s = pend_valid_r & boundary_s;
    end

    // One-deep pending configuration slot; ready is the registered inverse of occupancy.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pend_valid_r  <= 1'b0;
            pend_period_r <= {WIDTH{1'b0}};
            cfg_ready_r   <= 1'b1;
        end else if (accept_s) begin
            pend_valid_r  <= 1'b1;
            pend_period_r <= cfg_period;
            cfg_ready_r   <= 1'b0;
        end else if (apply_s) begin
            pend_valid_r  <= 1'b0;
            cfg_ready_r   <= 1'b1;
        end else begin
            pend_valid_r  <= pend_valid_r;
            cfg_ready_r   <= cfg_ready_r;
        end
    end

`ifdef CLK_DIV_DUTY_EN
    // Duty value travels with its period through the pending slot.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pend_duty_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            pend_duty_r <= cfg_duty;
        end else begin
            pend_duty_r <= pend_duty_r;
        end
    end

    // Active high time, swapped only at a period boundary.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            hi_r <= DEF_HI_C;
        end else if (apply_s) begin
            hi_r <= new_hi_s;
        end else begin
            hi_r <= hi_r;
        end
    end
`endif

    // Active period, swapped only at a period boundary.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            period_r <= DEF_PERIOD_C;
        end else if (apply_s) begin
            period_r <= new_period_s;
        end else begin
            period_r <= period_r;
        end
    end

    // IDLE/RUN control; outputs are registered from the next count so they line up with cnt_r.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {WIDTH{1'b0}};
            clk_out_r <= 1'b0;
            tick_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= {WIDTH{1'b0}};
                    clk_out_r <= 1'b0;
                    tick_r    <= 1'b0;
                    if (en) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        running_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (at_end_s) begin
                        // Low phase is never empty, so a fresh period always starts low.
                        cnt_r     <= {WIDTH{1'b0}};
                        clk_out_r <= 1'b0;
                        tick_r    <= 1'b0;
                        if (en) begin
                            state_r   <= ST_RUN;
                            running_r <= 1'b1;
                        end else begin
                            state_r   <= ST_IDLE;
                            running_r <= 1'b0;
                        end
                    end else begin
                        state_r   <= ST_RUN;
                        cnt_r     <= cnt_inc_s;
                        clk_out_r <= (cnt_inc_s >= lo_s);
                        tick_r    <= (cnt_inc_s == last_s);
                        running_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= {WIDTH{1'b0}};
                    clk_out_r <= 1'b0;
                    tick_r    <= 1'b0;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign clk_out   = clk_out_r;
    assign tick      = tick_r;
    assign running   = running_r;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (DIV_DEFAULT=8); duty checks added when CLK_DIV_DUTY_EN is defined.
module tb_clk_div_prog;

    localparam int W = 21;

    logic         clk_in = 1'b0;
    logic         rst;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_duty;
    logic         cfg_ready;
    logic         clk_out;
    logic         tick;
    logic         running;

    int vec_cnt = 0;
    int err_cnt = 0;

    clk_div_prog #(.WIDTH(W), .DIV_DEFAULT(8)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .clk_out    (clk_out),
        .tick       (tick),
        .running    (running)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;
        step();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) rst = 1'b0;
            exp = 4'b0001;
            vec_cnt++;
            if ({clk_out, tick, running, cfg_ready} !== exp) begin
                err_cnt++;
                $display("FAIL reset i=%0d {clk,tick,run,rdy} got %b want %b", i, {clk_out, tick, running, cfg_ready}, exp);
            end
            step();
        end
    endtask

    task automatic test_default_run();
        logic [2:0] exp;
        en = 1'b1;
        step();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 8; c++) begin
                exp = {1'b1, (c >= 4), (c == 7)};
                vec_cnt++;
                if ({running, clk_out, tick} !== exp) begin
                    err_cnt++;
                    $display("FAIL default_run p=%0d c=%0d {run,clk,tick} got %b want %b", p, c, {running, clk_out, tick}, exp);
                end
                step();
            end
        end
    endtask

    task automatic test_cfg_mid();
        logic [2:0] exp;
        step(); step();
        vec_cnt++;
        if (cfg_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL cfg_mid_ready got %b want 1", cfg_ready);
        end
        cfg_valid = 1'b1; cfg_period = W'(4);
        step();
        cfg_valid = 1'b0;
        for (int c = 3; c < 8; c++) begin
            exp = {1'b0, (c >= 4), (c == 7)};
            vec_cnt++;
            if ({cfg_ready, clk_out, tick} !== exp) begin
                err_cnt++;
                $display("FAIL cfg_mid_old c=%0d {rdy,clk,tick} got %b want %b", c, {cfg_ready, clk_out, tick}, exp);
            end
            step();
        end
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 4; c++) begin
                exp = {1'b1, (c >= 2), (c == 3)};
                vec_cnt++;
                if ({cfg_ready, clk_out, tick} !== exp) begin
                    err_cnt++;
                    $display("FAIL cfg_mid_new p=%0d c=%0d {rdy,clk,tick} got %b want %b", p, c, {cfg_ready, clk_out, tick}, exp);
                end
                step();
            end
        end
    endtask

    task automatic test_cfg_at_wrap();
        logic [2:0] exp;
        step(); step(); step();
        vec_cnt++;
        if ({cfg_ready, tick} !== 2'b11) begin
            err_cnt++;
            $display("FAIL wrap_offer {rdy,tick} got %b want 11", {cfg_ready, tick});
        end
        cfg_valid = 1'b1; cfg_period = W'(8);
        step();
        cfg_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            exp = {1'b0, (c >= 2), (c == 3)};
            vec_cnt++;
            if ({cfg_ready, clk_out, tick} !== exp) begin
                err_cnt++;
                $display("FAIL wrap_hold c=%0d {rdy,clk,tick} got %b want %b", c, {cfg_ready, clk_out, tick}, exp);
            end
            step();
        end
        for (int c = 0; c < 8; c++) begin
            exp = {1'b1, (c >= 4), (c == 7)};
            vec_cnt++;
            if ({cfg_ready, clk_out, tick} !== exp) begin
                err_cnt++;
                $display("FAIL wrap_new c=%0d {rdy,clk,tick} got %b want %b", c, {cfg_ready, clk_out, tick}, exp);
            end
            step();
        end
    endtask

    task automatic test_stop();
        logic [2:0] exp;
        step(); step(); step();
        en = 1'b0;
        for (int c = 3; c < 8; c++) begin
            exp = {1'b1, (c >= 4), (c == 7)};
            vec_cnt++;
            if ({running, clk_out, tick} !== exp) begin
                err_cnt++;
                $display("FAIL stop_finish c=%0d {run,clk,tick} got %b want %b", c, {running, clk_out, tick}, exp);
            end
            step();
        end
        for (int i = 0; i < 5; i++) begin
            vec_cnt++;
            if ({running, clk_out, tick} !== 3'b000) begin
                err_cnt++;
                $display("FAIL stop_idle i=%0d {run,clk,tick} got %b want 000", i, {running, clk_out, tick});
            end
            step();
        end
    endtask

    task automatic test_clamp();
        logic [3:0] exp;
        cfg_valid = 1'b1; cfg_period = W'(0);
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vec_cnt++;
            if ({running, cfg_ready} !== 2'b00) begin
                err_cnt++;
                $display("FAIL clamp_idle_pend i=%0d {run,rdy} got %b want 00", i, {running, cfg_ready});
            end
            step();
        end
        en = 1'b1;
        step();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 2; c++) begin
                exp = {1'b1, (c >= 1), (c == 1), 1'b1};
                vec_cnt++;
                if ({running, clk_out, tick, cfg_ready} !== exp) begin
                    err_cnt++;
                    $display("FAIL clamp_p0 p=%0d c=%0d {run,clk,tick,rdy} got %b want %b", p, c, {running, clk_out, tick, cfg_ready}, exp);
                end
                step();
            end
        end
        cfg_valid = 1'b1; cfg_period = W'(1);
        step();
        cfg_valid = 1'b0;
        vec_cnt++;
        if ({cfg_ready, tick} !== 2'b01) begin
            err_cnt++;
            $display("FAIL clamp_p1_pend {rdy,tick} got %b want 01", {cfg_ready, tick});
        end
        step();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 2; c++) begin
                exp = {1'b1, (c >= 1), (c == 1), 1'b1};
                vec_cnt++;
                if ({running, clk_out, tick, cfg_ready} !== exp) begin
                    err_cnt++;
                    $display("FAIL clamp_p1 p=%0d c=%0d {run,clk,tick,rdy} got %b want %b", p, c, {running, clk_out, tick, cfg_ready}, exp);
                end
                step();
            end
        end
        cfg_valid = 1'b1; cfg_period = W'(5);
        step();
        cfg_valid = 1'b0;
        step();
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 5; c++) begin
                exp = {1'b1, (c >= 3), (c == 4), 1'b1};
                vec_cnt++;
                if ({running, clk_out, tick, cfg_ready} !== exp) begin
                    err_cnt++;
                    $display("FAIL period5 p=%0d c=%0d {run,clk,tick,rdy} got %b want %b", p, c, {running, clk_out, tick, cfg_ready}, exp);
                end
                step();
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp;
        step(); step(); step();
        vec_cnt++;
        if (clk_out !== 1'b1) begin
            err_cnt++;
            $display("FAIL rst_mid_pre clk got %b want 1", clk_out);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec_cnt++;
        if ({clk_out, tick, running, cfg_ready} !== 4'b0001) begin
            err_cnt++;
            $display("FAIL rst_mid {clk,tick,run,rdy} got %b want 0001", {clk_out, tick, running, cfg_ready});
        end
        step();
        for (int c = 0; c < 8; c++) begin
            exp = {1'b1, (c >= 4), (c == 7)};
            vec_cnt++;
            if ({running, clk_out, tick} !== exp) begin
                err_cnt++;
                $display("FAIL rst_mid_default c=%0d {run,clk,tick} got %b want %b", c, {running, clk_out, tick}, exp);
            end
            step();
        end
    endtask

`ifdef CLK_DIV_DUTY_EN
    task automatic test_duty();
        logic [1:0] exp;
        int duty_v[3];
        int lo_v[3];
        duty_v = '{3, 0, 12};
        lo_v   = '{7, 9, 1};
        for (int k = 0; k < 3; k++) begin
            cfg_valid = 1'b1; cfg_period = W'(10); cfg_duty = W'(duty_v[k]);
            step();
            cfg_valid = 1'b0;
            repeat ((k == 0) ? 7 : 9) step();
            for (int c = 0; c < 10; c++) begin
                exp = {(c >= lo_v[k]), (c == 9)};
                vec_cnt++;
                if ({clk_out, tick} !== exp) begin
                    err_cnt++;
                    $display("FAIL duty%0d c=%0d {clk,tick} got %b want %b", duty_v[k], c, {clk_out, tick}, exp);
                end
                step();
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_default_run();
        test_cfg_mid();
        test_cfg_at_wrap();
        test_stop();
        test_clamp();
        test_reset_mid();
`ifdef CLK_DIV_DUTY_EN
        test_duty();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
